// File: rtl/present_core_clkgen.sv
// Multi-channel digital clock generator: per-channel divide/high/phase, rising-edge strobes, lock detect.
// Define CLKGEN_PHASE_EN to enable per-channel programmable phase; otherwise cfg_phase is ignored.
module present_core_clkgen #(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned GATE_UNLOCK = 1,
  localparam int unsigned CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] strobe,
  output logic                  locked
);

  localparam int unsigned SET_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, SETTLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [DIV_W-1:0] div_q   [NUM_CLOCKS];
  logic [DIV_W-1:0] high_q  [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt     [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt_nxt [NUM_CLOCKS];
  logic [DIV_W-1:0] div_cl, high_cl;
  logic             write, gate_open;

`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0] phase_q [NUM_CLOCKS];
  logic [DIV_W-1:0] phase_cl;
`else
  logic             unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  // Writes to a channel index beyond NUM_CLOCKS handshake but are dropped here.
  assign write     = cfg_valid && cfg_ready && (32'(cfg_chan) < NUM_CLOCKS);
  assign gate_open = (GATE_UNLOCK == 0) || (state_nxt == LOCKED);

  // Clamp incoming config to a legal divide/high/phase triple.
  always_comb begin
    div_cl  = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    high_cl = cfg_high;
    if (cfg_high == '0)
      high_cl = DIV_W'(1);
    else if (cfg_high >= div_cl)
      high_cl = div_cl - DIV_W'(1);
`ifdef CLKGEN_PHASE_EN
    phase_cl = cfg_phase % div_cl;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) state_nxt = LOCKED;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = SYNC;
    endcase
    if (write)
      state_nxt = SYNC;
  end

  // SYNC preloads each counter so that its first wrap lands 'phase' cycles into SETTLE.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (state == SYNC) begin
`ifdef CLKGEN_PHASE_EN
        cnt_nxt[i] = (phase_q[i] == '0) ? '0 : DIV_W'(div_q[i] - phase_q[i]);
`else
        cnt_nxt[i] = '0;
`endif
      end else if (cnt[i] >= div_q[i] - DIV_W'(1)) begin
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= SYNC;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      outclk     <= '0;
      strobe     <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        high_q[i]  <= DIV_W'(DEFAULT_DIV / 2);
        cnt[i]     <= '0;
`ifdef CLKGEN_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == SETTLE && state_nxt == SETTLE) ? settle_cnt + SET_W'(1) : '0;
      locked     <= (state_nxt == LOCKED);
      cfg_ready  <= (state_nxt != SYNC);
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt[i]    <= cnt_nxt[i];
        outclk[i] <= gate_open && (cnt_nxt[i] < high_q[i]);
        strobe[i] <= gate_open && (cnt_nxt[i] == '0);
        if (write && cfg_chan == CHAN_W'(i)) begin
          div_q[i]   <= div_cl;
          high_q[i]  <= high_cl;
`ifdef CLKGEN_PHASE_EN
          phase_q[i] <= phase_cl;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_present_core_clkgen.sv
// Scoreboard bench for present_core_clkgen: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_present_core_clkgen;

  localparam logic [9:0] ALL = 10'h3FF;

  // Observed word: {cfg_ready, locked, strobe[3:0], outclk[3:0]}
  localparam logic [9:0] EXP_W1 [7] = '{10'h3DF, 10'h300, 10'h3DD, 10'h300, 10'h3FF, 10'h302, 10'h3DD};
`ifdef CLKGEN_PHASE_EN
  localparam logic [9:0] EXP_PH [8] = '{10'h111, 10'h100, 10'h111, 10'h144, 10'h115, 10'h104, 10'h115, 10'h100};
`else
  localparam logic [9:0] EXP_PH [8] = '{10'h155, 10'h104, 10'h115, 10'h104, 10'h111, 10'h100, 10'h111, 10'h100};
`endif
  localparam logic [9:0] EXP_CL [5] = '{10'h199, 10'h101, 10'h189, 10'h100, 10'h199};

  logic       refclk = 1'b0;
  logic       rst, cfg_valid, cfg_ready, locked;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div, cfg_high, cfg_phase;
  logic [3:0] outclk, strobe;
  logic [9:0] obs;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int    q_cyc  [$];
  logic [9:0] q_mask [$];
  logic [9:0] q_val  [$];
  string q_name [$];

  present_core_clkgen dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .strobe    (strobe),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [9:0] m, input logic [9:0] v, input string n);
    q_cyc.push_back(c);
    q_mask.push_back(m);
    q_val.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic cfg_write(input int ch, input int d, input int h, input int p, output int t);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = 8'(d);
    cfg_high  = 8'(h);
    cfg_phase = 8'(p);
    t = cyc;
    expect_at(t, 10'h200, 10'h200, "ready_at_write");
    tick();
    cfg_valid = 1'b0;
  endtask

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge refclk) begin
    obs = {cfg_ready, locked, strobe, outclk};
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] <= cyc) begin
        vectors++;
        if (q_cyc[i] < cyc) begin
          miscompares++;
          $display("FAIL %s cyc=%0d stale expectation for cyc %0d", q_name[i], cyc, q_cyc[i]);
        end else if (((obs ^ q_val[i]) & q_mask[i]) != '0) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", q_name[i], cyc, obs & q_mask[i],
                   q_val[i] & q_mask[i], q_mask[i]);
        end
        q_cyc.delete(i);
        q_mask.delete(i);
        q_val.delete(i);
        q_name.delete(i);
      end
    end
  end

  initial begin
    int r, t, t3, t4;
    rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_div = '0; cfg_high = '0; cfg_phase = '0;

    // Reset and default lock: all channels div 2
    repeat (3) tick();
    expect_at(cyc, ALL, 10'h000, "reset_state");
    r = cyc;
    rst = 1'b0;
    expect_at(r + 1,  ALL, 10'h200, "sync_exit_ready");
    expect_at(r + 16, ALL, 10'h200, "pre_lock");
    expect_at(r + 17, ALL, 10'h3FF, "lock_rise");
    expect_at(r + 18, ALL, 10'h300, "div2_low");
    expect_at(r + 19, ALL, 10'h3FF, "div2_high");
    repeat (22) tick();

    // ch1 div 5 high 2
    cfg_write(1, 5, 2, 0, t);
    expect_at(t + 1,  ALL, 10'h000, "locked_drop");
    expect_at(t + 2,  ALL, 10'h200, "settle_entry");
    expect_at(t + 17, ALL, 10'h200, "w1_pre_lock");
    for (int k = 0; k < 7; k++) expect_at(t + 18 + k, ALL, EXP_W1[k], "w1_pattern");
    repeat (26) tick();

    // ch2 div 8 high 4 phase 3
    cfg_write(2, 8, 4, 3, t);
    expect_at(t + 17, 10'h100, 10'h000, "ph_pre_lock");
    for (int k = 0; k < 8; k++) expect_at(t + 18 + k, 10'h155, EXP_PH[k], "phase_align");
    repeat (27) tick();

    // Clamp writes; second lands in SETTLE and restarts the settle count
    cfg_write(3, 1, 0, 0, t3);
    repeat (4) tick();
    cfg_write(0, 4, 9, 0, t4);
    expect_at(t4 + 1,  10'h300, 10'h000, "resync");
    expect_at(t3 + 18, 10'h100, 10'h000, "settle_restart");
    expect_at(t4 + 17, 10'h100, 10'h000, "restart_pre_lock");
    for (int k = 0; k < 5; k++) expect_at(t4 + 18 + k, 10'h199, EXP_CL[k], "clamp_pattern");
    repeat (25) tick();

    // Reset while locked with programmed channels
    rst = 1'b1;
    expect_at(cyc + 1, ALL, 10'h000, "rst_mid");
    tick();
    r = cyc;
    rst = 1'b0;
    expect_at(r + 16, ALL, 10'h200, "rst_pre_lock");
    expect_at(r + 17, ALL, 10'h3FF, "rst_defaults_high");
    expect_at(r + 18, ALL, 10'h300, "rst_defaults_low");
    expect_at(r + 19, ALL, 10'h3FF, "rst_defaults_high2");

    for (int i = 0; i < 60 && q_cyc.size() != 0; i++) tick();
    if (q_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", q_cyc.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
